// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the 8-bit ALU system datapath: two-byte fetch, decode, 1-2 execute cycles.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT with Illegal=1 instead of executing as a NOP.
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        InstrDone,
    output logic        Halted,
    output logic        Illegal
);

    localparam logic [3:0] ALU_PASSA = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h4;
    localparam logic [3:0] ALU_SUB   = 4'h6;
    localparam logic [3:0] ALU_AND   = 4'h7;
    localparam logic [3:0] ALU_OR    = 4'h8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BRA  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_FETCH_L = 3'd1;
    localparam logic [2:0] S_FETCH_H = 3'd2;
    localparam logic [2:0] S_EXEC1   = 3'd3;
    localparam logic [2:0] S_EXEC2   = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [1:0] FUN_CLEAR = 2'b00;
    localparam logic [1:0] FUN_LOAD  = 2'b01;
    localparam logic [1:0] FUN_INC   = 2'b11;

    logic [2:0] state_q, state_d;
    logic       z_q, z_d;

    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] rd_onehot;
    logic [3:0] alu_code;
    logic       unused_bits;

    assign opcode    = IROut[15:12];
    assign rd        = IROut[11:10];
    assign rs        = IROut[9:8];
    assign rd_onehot = 4'b0001 << rd;

    // Immediates and addresses reach the datapath through MuxA/MuxB, so the controller never reads them.
    assign unused_bits = ^{IROut[7:0], ALUOutFlag[2:0]};

    always_comb begin
        case (opcode)
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            OP_AND:  alu_code = ALU_AND;
            OP_OR:   alu_code = ALU_OR;
            default: alu_code = ALU_PASSA;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_INIT:    state_d = S_FETCH_L;
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_EXEC1;
            S_EXEC1: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        z_d     = ALUOutFlag[3];
                        state_d = S_FETCH_L;
                    end
                    OP_LDI, OP_BRA, OP_BNE: state_d = S_FETCH_L;
                    OP_LD, OP_ST:           state_d = S_EXEC2;
                    OP_HALT:                state_d = S_HALT;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH_L;
`endif
                    end
                endcase
            end
            S_EXEC2: state_d = S_FETCH_L;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_INIT;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    // Moore-style control decode: every output starts inactive and each state enables only what it needs.
    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = FUN_CLEAR;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = ALU_PASSA;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = FUN_CLEAR;
        ARF_RegSel  = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        InstrDone   = 1'b0;
        Halted      = 1'b0;
        case (state_q)
            S_INIT: begin
                RF_RSel    = 4'b1111;
                ARF_RegSel = 4'b0111;
            end
            S_FETCH_L, S_FETCH_H: begin
                Mem_CS     = 1'b0;
                IR_Enable  = 1'b1;
                IR_Funsel  = FUN_LOAD;
                IR_LH      = (state_q == S_FETCH_H);
                ARF_RegSel = 4'b0001;
                ARF_FunSel = FUN_INC;
            end
            S_EXEC1: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RF_OutASel = {1'b0, rd};
                        RF_OutBSel = {1'b0, rs};
                        ALU_FunSel = alu_code;
                        RF_RSel    = rd_onehot;
                        RF_FunSel  = FUN_LOAD;
                        InstrDone  = 1'b1;
                    end
                    OP_LDI: begin
                        MuxASel   = 2'b10;
                        RF_RSel   = rd_onehot;
                        RF_FunSel = FUN_LOAD;
                        InstrDone = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        MuxBSel    = 2'b10;
                        ARF_RegSel = 4'b0010;
                        ARF_FunSel = FUN_LOAD;
                    end
                    OP_BRA: begin
                        MuxBSel    = 2'b10;
                        ARF_RegSel = 4'b0001;
                        ARF_FunSel = FUN_LOAD;
                        InstrDone  = 1'b1;
                    end
                    OP_BNE: begin
                        if (!z_q) begin
                            MuxBSel    = 2'b10;
                            ARF_RegSel = 4'b0001;
                            ARF_FunSel = FUN_LOAD;
                        end
                        InstrDone = 1'b1;
                    end
                    OP_HALT: begin
                    end
                    default: begin
`ifndef CU_ILLEGAL_TRAP_EN
                        InstrDone = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC2: begin
                ARF_OutDSel = 2'b01;
                Mem_CS      = 1'b0;
                InstrDone   = 1'b1;
                if (opcode == OP_LD) begin
                    MuxASel   = 2'b01;
                    RF_RSel   = rd_onehot;
                    RF_FunSel = FUN_LOAD;
                end else begin
                    RF_OutASel = {1'b0, rs};
                    ALU_FunSel = ALU_PASSA;
                    Mem_WR     = 1'b1;
                end
            end
            S_HALT: Halted = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: drives IROut/ALUOutFlag by hand and checks control outputs per state.
module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic        InstrDone, Halted, Illegal;

    int          total_count;
    int          bad_count;
    logic [7:0]  pc_model;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .InstrDone(InstrDone), .Halted(Halted), .Illegal(Illegal)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Minimal model of the 8-bit PC register so branch and fetch effects can be observed.
    always @(posedge Clock) begin
        if (ARF_RegSel[0]) begin
            case (ARF_FunSel)
                2'b00: pc_model <= 8'h00;
                2'b01: pc_model <= (MuxBSel == 2'b10) ? IROut[7:0] : pc_model;
                2'b10: pc_model <= pc_model - 8'h01;
                2'b11: pc_model <= pc_model + 8'h01;
                default: pc_model <= pc_model;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ir, input logic [3:0] flags);
        IROut      = ir;
        ALUOutFlag = flags;
    endtask

    task automatic next_cycle();
        @(negedge Clock);
    endtask

    task automatic check_init(input string tag);
        checkOutput({tag, "_rf_rsel"},   {12'h0, RF_RSel},    16'h000F);
        checkOutput({tag, "_arf_rsel"},  {12'h0, ARF_RegSel}, 16'h0007);
        checkOutput({tag, "_rf_fun"},    {14'h0, RF_FunSel},  16'h0000);
        checkOutput({tag, "_arf_fun"},   {14'h0, ARF_FunSel}, 16'h0000);
        checkOutput({tag, "_mem"},       {14'h0, Mem_WR, Mem_CS}, 16'h0001);
        checkOutput({tag, "_flags"},     {13'h0, InstrDone, Halted, Illegal}, 16'h0000);
    endtask

    // Checks FETCH_L and FETCH_H, loads the next instruction, and leaves the bench in EXEC1.
    task automatic run_fetch(input logic [15:0] ir, input logic [3:0] flags);
        checkOutput("fetchl_ir",  {12'h0, IR_Enable, IR_LH, IR_Funsel}, 16'h0009);
        checkOutput("fetchl_pc",  {8'h0, ARF_RegSel, ARF_FunSel, ARF_OutDSel}, 16'h001C);
        checkOutput("fetchl_mem", {14'h0, Mem_WR, Mem_CS}, 16'h0000);
        next_cycle();
        checkOutput("fetchh_ir",  {12'h0, IR_Enable, IR_LH, IR_Funsel}, 16'h000D);
        checkOutput("fetchh_done", {15'h0, InstrDone}, 16'h0000);
        applyStimulus(ir, flags);
        next_cycle();
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        pc_model    = 8'h55;
        Reset       = 1'b0;
        applyStimulus(16'h0000, 4'h0);
        #2;
        check_init("rst_low");
        checkOutput("rst_tsel", {12'h0, RF_TSel}, 16'h0000);
        next_cycle();
        next_cycle();
        Reset = 1'b1;
        check_init("init");
        next_cycle();

        run_fetch(16'h4005, 4'h0);
        checkOutput("ldi_muxa",  {14'h0, MuxASel}, 16'h0002);
        checkOutput("ldi_rsel",  {12'h0, RF_RSel}, 16'h0001);
        checkOutput("ldi_fun",   {14'h0, RF_FunSel}, 16'h0001);
        checkOutput("ldi_done",  {15'h0, InstrDone}, 16'h0001);
        checkOutput("ldi_pc",    {8'h0, pc_model}, 16'h0002);
        next_cycle();

        run_fetch(16'h0100, 4'b1000);
        checkOutput("add_fun",   {12'h0, ALU_FunSel}, 16'h0004);
        checkOutput("add_outa",  {13'h0, RF_OutASel}, 16'h0000);
        checkOutput("add_outb",  {13'h0, RF_OutBSel}, 16'h0001);
        checkOutput("add_rsel",  {12'h0, RF_RSel}, 16'h0001);
        checkOutput("add_muxes", {11'h0, MuxASel, MuxBSel, MuxCSel}, 16'h0000);
        next_cycle();

        run_fetch(16'h8030, 4'h0);
        checkOutput("bne_nt_rsel", {12'h0, ARF_RegSel}, 16'h0000);
        checkOutput("bne_nt_done", {15'h0, InstrDone}, 16'h0001);
        next_cycle();

        run_fetch(16'h5420, 4'h0);
        checkOutput("ld1_muxb",  {14'h0, MuxBSel}, 16'h0002);
        checkOutput("ld1_arf",   {10'h0, ARF_RegSel, ARF_FunSel}, 16'h0009);
        checkOutput("ld1_done",  {15'h0, InstrDone}, 16'h0000);
        next_cycle();
        checkOutput("ld2_outd",  {14'h0, ARF_OutDSel}, 16'h0001);
        checkOutput("ld2_mem",   {14'h0, Mem_WR, Mem_CS}, 16'h0000);
        checkOutput("ld2_muxa",  {14'h0, MuxASel}, 16'h0001);
        checkOutput("ld2_rsel",  {12'h0, RF_RSel}, 16'h0002);
        checkOutput("ld2_done",  {15'h0, InstrDone}, 16'h0001);
        next_cycle();

        run_fetch(16'h3600, 4'b0000);
        checkOutput("or_fun",    {12'h0, ALU_FunSel}, 16'h0008);
        checkOutput("or_rsel",   {12'h0, RF_RSel}, 16'h0002);
        checkOutput("or_outb",   {13'h0, RF_OutBSel}, 16'h0002);
        next_cycle();

        run_fetch(16'h8030, 4'h0);
        checkOutput("bne_t_arf",  {10'h0, ARF_RegSel, ARF_FunSel}, 16'h0005);
        checkOutput("bne_t_muxb", {14'h0, MuxBSel}, 16'h0002);
        next_cycle();

        run_fetch(16'h6110, 4'h0);
        checkOutput("st1_pc",    {8'h0, pc_model}, 16'h0032);
        checkOutput("st1_arf",   {12'h0, ARF_RegSel}, 16'h0002);
        next_cycle();
        checkOutput("st2_mem",   {14'h0, Mem_WR, Mem_CS}, 16'h0002);
        checkOutput("st2_outa",  {13'h0, RF_OutASel}, 16'h0001);
        checkOutput("st2_alu",   {12'h0, ALU_FunSel}, 16'h0000);
        checkOutput("st2_outd",  {14'h0, ARF_OutDSel}, 16'h0001);
        #2 Reset = 1'b0;
        #1;
        checkOutput("abort_mem",  {14'h0, Mem_WR, Mem_CS}, 16'h0001);
        checkOutput("abort_rsel", {12'h0, RF_RSel}, 16'h000F);
        next_cycle();
        Reset = 1'b1;
        check_init("reinit");
        next_cycle();

        run_fetch(16'hA000, 4'h0);
        checkOutput("ill_pc", {8'h0, pc_model}, 16'h0002);
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            checkOutput("trap_state", {13'h0, InstrDone, Halted, Illegal}, 16'h0003);
            checkOutput("trap_quiet", {10'h0, ARF_RegSel, IR_Enable, Mem_CS}, 16'h0001);
        end
        Reset = 1'b0;
        #1;
        checkOutput("trap_rst", {14'h0, Halted, Illegal}, 16'h0000);
        next_cycle();
        Reset = 1'b1;
        next_cycle();
        run_fetch(16'hF000, 4'h0);
`else
        checkOutput("nop_done",   {15'h0, InstrDone}, 16'h0001);
        checkOutput("nop_writes", {8'h0, RF_RSel, ARF_RegSel}, 16'h0000);
        checkOutput("nop_mem",    {14'h0, Mem_WR, Mem_CS}, 16'h0001);
        next_cycle();
        run_fetch(16'hF000, 4'h0);
        checkOutput("nop_next_pc", {8'h0, pc_model}, 16'h0004);
`endif
        checkOutput("halt_e1", {14'h0, InstrDone, Halted}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checkOutput("halt_state", {14'h0, Halted, Illegal}, 16'h0002);
            checkOutput("halt_quiet", {8'h0, RF_RSel, ARF_RegSel}, 16'h0000);
            checkOutput("halt_ir",    {14'h0, IR_Enable, Mem_CS}, 16'h0001);
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
